// File: rtl/mem_interface.sv
// Unified instruction/data memory stage for the multicycle CPU.
// Accepts one read or write per request, inserts WAIT_CYCLES busy cycles,
// completes the access, then pulses ready for one cycle. Owns the word
// memory, the instruction register and the memory data register.
module mem_interface #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        iord,
    input  logic        ir_write,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                is_wr_q, is_wr_d;
    logic                to_ir_q, to_ir_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                req_c;
    logic                addr_ok_c;
    logic                access_c;
    logic [ADDR_W-1:0]   idx_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic [DATA_W-1:0]   sel_addr_c;

    // Decode of the latched address and the access edge
    always_comb begin
        req_c      = mem_read | mem_write;
        sel_addr_c = iord ? alu_out : pc;
        idx_c      = addr_q[ADDR_W+1:2];
        addr_ok_c  = (addr_q[1:0] == 2'b00) && (addr_q[DATA_W-1:ADDR_W+2] == '0);
        access_c   = (state_q == BUSY) && (cnt_q == '0);
        rd_data_c  = mem_q[idx_c];
    end

    // Next-state and register updates for the access sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        mdr_d   = mdr_q;
        is_wr_d = is_wr_q;
        to_ir_d = to_ir_q;
        ready_d = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    addr_d  = sel_addr_c;
                    wdata_d = wdata;
                    is_wr_d = mem_write;
                    to_ir_d = ir_write;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = BUSY;
                    // Simultaneous read and write resolves as a write
                    if (mem_read && mem_write) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (!addr_ok_c) begin
                        err_d = 1'b1;
                    end
                    // Bad addresses load zero into the read destination
                    if (!is_wr_q) begin
                        if (to_ir_q) begin
                            instr_d = addr_ok_c ? rd_data_c : '0;
                        end else begin
                            mdr_d   = addr_ok_c ? rd_data_c : '0;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= '0;
            mdr_q   <= '0;
            is_wr_q <= 1'b0;
            to_ir_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            is_wr_q <= is_wr_d;
            to_ir_q <= to_ir_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Word memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (access_c && is_wr_q && addr_ok_c) begin
            mem_q[idx_c] <= wdata_q;
        end
    end

    assign instr = instr_q;
    assign mdr   = mdr_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign stall = req_c & ~ready_q;

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: one instance with two wait states,
// one with none. Expected responses are queued at accept and checked by a
// monitor whenever ready is seen.
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd   [2];
    logic        wr   [2];
    logic        iord [2];
    logic        irw  [2];
    logic [31:0] pc   [2];
    logic [31:0] alu  [2];
    logic [31:0] wd   [2];
    logic [31:0] instr[2];
    logic [31:0] mdr  [2];
    logic        ready[2];
    logic        stall[2];
    logic        err  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mdr;
        logic        err;
        int          rdy_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    mem_interface #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .mem_read(rd[0]), .mem_write(wr[0]), .iord(iord[0]), .ir_write(irw[0]),
        .pc(pc[0]), .alu_out(alu[0]), .wdata(wd[0]),
        .instr(instr[0]), .mdr(mdr[0]), .ready(ready[0]), .stall(stall[0]), .err(err[0])
    );

    mem_interface #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .mem_read(rd[1]), .mem_write(wr[1]), .iord(iord[1]), .ir_write(irw[1]),
        .pc(pc[1]), .alu_out(alu[1]), .wdata(wd[1]),
        .instr(instr[1]), .mdr(mdr[1]), .ready(ready[1]), .stall(stall[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Monitor: pop and compare on every ready pulse
    always @(negedge clk) begin : mon
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            have = 1'b0;
            if (ready[d] === 1'b1) begin
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready dut%0d: got ready 1 want 0", d);
                end else begin
                    chk($sformatf("instr_dut%0d", d), instr[d], e.instr);
                    chk($sformatf("mdr_dut%0d", d), mdr[d], e.mdr);
                    chk($sformatf("err_dut%0d", d), 32'(err[d]), 32'(e.err));
                    chk($sformatf("ready_cycle_dut%0d", d), 32'(cyc), 32'(e.rdy_cyc));
                end
            end
        end
    end

    task automatic push_exp(input int d, input logic [31:0] ei, input logic [31:0] em,
                            input logic ee, input int rc);
        exp_t e;
        e.instr   = ei;
        e.mdr     = em;
        e.err     = ee;
        e.rdy_cyc = rc;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Wait for the ready pulse, checking stall while busy and in the ready cycle
    task automatic wait_ready(input int d);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ready[d] === 1'b1) seen = 1'b1;
            else chk("stall_busy", 32'(stall[d]), 32'd1);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ready_timeout dut%0d: got no ready want ready", d);
        end else begin
            chk("stall_resp", 32'(stall[d]), 32'd0);
        end
    endtask

    task automatic xact(input int d, input logic r, input logic w, input logic io,
                        input logic ir, input logic [31:0] a, input logic [31:0] dat,
                        input logic [31:0] ei, input logic [31:0] em, input logic ee);
        int acc;
        @(negedge clk);
        rd[d] = r; wr[d] = w; iord[d] = io; irw[d] = ir; wd[d] = dat;
        if (io) alu[d] = a;
        else    pc[d]  = a;
        #1;
        chk("stall_request", 32'(stall[d]), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        push_exp(d, ei, em, ee, acc + ((d == 0) ? 2 : 0) + 1);
        wait_ready(d);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] bv [3];
        int acc;
        int prev;
        bit drained;

        bv[0] = 32'h1111_1111;
        bv[1] = 32'h2222_2222;
        bv[2] = 32'h3333_3333;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; iord[d] = 1'b0; irw[d] = 1'b0;
            pc[d] = '0; alu[d] = '0; wd[d] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_instr", instr[d], 32'h0);
            chk("rst_mdr", mdr[d], 32'h0);
            chk("rst_ready", 32'(ready[d]), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_stall", 32'(stall[d]), 32'd0);
        end
        rst = 1'b1;

        // dut0, two wait states: rd, wr, iord, ir_write, addr, wdata -> instr, mdr, err
        xact(0, 0, 1, 1, 0, 32'h0,       32'h8C01_0004, 32'h0,          32'h0,          0);
        xact(0, 1, 0, 0, 1, 32'h0,       32'h0,         32'h8C01_0004,  32'h0,          0);
        xact(0, 0, 1, 1, 0, 32'h10,      32'hDEAD_BEEF, 32'h8C01_0004,  32'h0,          0);
        xact(0, 1, 0, 1, 0, 32'h10,      32'h0,         32'h8C01_0004,  32'hDEAD_BEEF,  0);
        xact(0, 1, 0, 1, 0, 32'h6,       32'h0,         32'h8C01_0004,  32'h0,          1);
        xact(0, 1, 0, 1, 0, 32'h10,      32'h0,         32'h8C01_0004,  32'hDEAD_BEEF,  1);
        xact(0, 1, 0, 1, 0, 32'h1_0000,  32'h0,         32'h8C01_0004,  32'h0,          1);
        xact(0, 0, 1, 1, 0, 32'h12,      32'h0000_0BAD, 32'h8C01_0004,  32'h0,          1);
        xact(0, 1, 1, 1, 0, 32'h14,      32'h0000_55AA, 32'h8C01_0004,  32'h0,          1);
        xact(0, 1, 0, 1, 0, 32'h10,      32'h0,         32'h8C01_0004,  32'hDEAD_BEEF,  1);
        xact(0, 1, 0, 1, 0, 32'h14,      32'h0,         32'h8C01_0004,  32'h0000_55AA,  1);

        // Reset during the busy phase of a store to word 4
        @(negedge clk);
        wr[0] = 1'b1; iord[0] = 1'b1; alu[0] = 32'h10; wd[0] = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        chk("stall_before_reset", 32'(stall[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_instr", instr[0], 32'h0);
        chk("midrst_mdr", mdr[0], 32'h0);
        chk("midrst_ready", 32'(ready[0]), 32'd0);
        chk("midrst_err", 32'(err[0]), 32'd0);
        @(negedge clk);
        wr[0] = 1'b0;
        rst = 1'b1;
        xact(0, 1, 0, 1, 0, 32'h10, 32'h0, 32'h0,          32'hDEAD_BEEF, 0);
        xact(0, 1, 0, 0, 1, 32'h0,  32'h0, 32'h8C01_0004,  32'hDEAD_BEEF, 0);

        // dut1, no wait states: fill words 0..2, then back-to-back fetches
        for (int k = 0; k < 3; k++)
            xact(1, 0, 1, 1, 0, 32'(k * 4), bv[k], 32'h0, 32'h0, 0);
        @(negedge clk);
        rd[1] = 1'b1; irw[1] = 1'b1; iord[1] = 1'b0; pc[1] = 32'h0;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            acc = cyc;
            push_exp(1, bv[k], 32'h0, 1'b0, acc + 1);
            if (k > 0) chk("b2b_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
            wait_ready(1);
            if (k < 2) begin
                pc[1] = 32'((k + 1) * 4);
                @(posedge clk);
            end else begin
                rd[1] = 1'b0;
            end
        end

        drained = 1'b0;
        for (int k = 0; k < 20 && !drained; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) drained = 1'b1;
        end
        if (!drained) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q0.size() + q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
